// File: rtl/if_fetch_controller_if.sv
// if_fetch_controller_if: instruction-memory, redirect and decode handshake bundle
interface if_fetch_controller_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] imem_address;
  logic [31:0]           imem_instruction;
  logic                  branch_taken;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  id_valid;
  logic                  id_ready;
  logic [31:0]           id_instruction;
  logic [ADDR_WIDTH-1:0] id_pc;
  logic                  halted;
  logic [15:0]           fetch_count;
  modport master (
    output imem_address, id_valid, id_instruction, id_pc, halted, fetch_count,
    input  imem_instruction, branch_taken, branch_target, id_ready
  );
  modport slave (
    input  imem_address, id_valid, id_instruction, id_pc, halted, fetch_count,
    output imem_instruction, branch_taken, branch_target, id_ready
  );
endinterface

// File: rtl/if_fetch_controller.sv
// if_fetch_controller: PC sequencing, prefetch FIFO, branch redirect and end-of-program halt
module if_fetch_controller #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = 4,
  parameter int                    FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] MEM_LIMIT  = ADDR_WIDTH'(28)
) (
  input logic clk,
  input logic rst_n,
  if_fetch_controller_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [CW-1:0]         count_q;
  logic [PW-1:0]         wr_q, rd_q;
  logic [31:0]           instr_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] epc_q   [FIFO_DEPTH];
  logic [15:0]           fetch_count_q;
  logic                  redirect, pop, push;
  logic [ADDR_WIDTH-1:0] target;
  assign target   = {bus.branch_target[ADDR_WIDTH-1:2], 2'b00};
  assign redirect = bus.branch_taken && state_q != IDLE;
  assign pop      = count_q != '0 && bus.id_ready;
  assign push     = state_q == FETCH && !redirect && pc_q < MEM_LIMIT &&
                    (count_q < CW'(FIFO_DEPTH) || pop);
  assign bus.imem_address   = pc_q;
  assign bus.id_valid       = count_q != '0;
  assign bus.id_instruction = instr_q[rd_q];
  assign bus.id_pc          = epc_q[rd_q];
  assign bus.halted         = state_q == HALT && count_q == '0;
  assign bus.fetch_count    = fetch_count_q;
  // State, PC and FIFO update; a redirect flushes the FIFO and wins over sequential fetch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      count_q       <= '0;
      wr_q          <= '0;
      rd_q          <= '0;
      fetch_count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_q[i] <= '0;
        epc_q[i]   <= '0;
      end
    end else begin
      if (state_q == IDLE) state_q <= (RESET_PC >= MEM_LIMIT) ? HALT : FETCH;
      else if (redirect) state_q <= (target < MEM_LIMIT) ? FETCH : HALT;
      else if (state_q == FETCH && pc_q >= MEM_LIMIT) state_q <= HALT;
      if (redirect) begin
        pc_q    <= target;
        count_q <= '0;
        wr_q    <= '0;
        rd_q    <= '0;
      end else begin
        if (push) begin
          instr_q[wr_q] <= bus.imem_instruction;
          epc_q[wr_q]   <= pc_q;
          wr_q          <= wr_q + 1'b1;
          pc_q          <= pc_q + ADDR_WIDTH'(PC_STEP);
        end
        if (pop) rd_q <= rd_q + 1'b1;
        count_q <= count_q + CW'(push) - CW'(pop);
      end
      if (push && fetch_count_q != '1) fetch_count_q <= fetch_count_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_if_fetch_controller.sv
// tb_if_fetch_controller: directed stimulus with a scoreboard of expected decode deliveries
module tb_if_fetch_controller;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_q [$];
  if_fetch_controller_if #(.ADDR_WIDTH(32)) bus ();
  if_fetch_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  always #5 clk = ~clk;
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction
  assign bus.imem_instruction = instr_of(bus.imem_address);
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask
  task automatic expect_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({start + 32'(4 * i), instr_of(start + 32'(4 * i))});
  endtask
  task automatic branch(input logic [31:0] t);
    bus.branch_taken  = 1'b1;
    bus.branch_target = t;
    tick();
    bus.branch_taken  = 1'b0;
  endtask
  task automatic wait_halt();
    for (int i = 0; i < 40 && !bus.halted; i++) tick();
    check("halt_reached", 64'(bus.halted), 64'd1);
  endtask
  // Monitor: every accepted head must match the next expected delivery
  always @(negedge clk) begin
    if (rst_n && bus.id_valid && bus.id_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got pc %h, required no delivery", bus.id_pc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({bus.id_pc, bus.id_instruction} !== e) begin
          errors++;
          $display("FAIL pop_data: got %h, required %h", {bus.id_pc, bus.id_instruction}, e);
        end
      end
    end
  end
  initial begin
    rst_n = 1'b0;
    bus.id_ready = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;
    tick();
    tick();
    check("rst_valid", 64'(bus.id_valid), 64'd0);
    check("rst_instr", 64'(bus.id_instruction), 64'd0);
    check("rst_pc", 64'(bus.id_pc), 64'd0);
    check("rst_halted", 64'(bus.halted), 64'd0);
    check("rst_count", 64'(bus.fetch_count), 64'd0);
    check("rst_addr", 64'(bus.imem_address), 64'd0);
    expect_seq(32'd0, 7);
    bus.id_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    check("idle_no_valid", 64'(bus.id_valid), 64'd0);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("stream_valid", 64'(bus.id_valid), 64'd1);
      check("stream_pc", 64'(bus.id_pc), 64'(4 * k));
    end
    tick();
    check("end_halted", 64'(bus.halted), 64'd1);
    check("end_count", 64'(bus.fetch_count), 64'd7);
    bus.id_ready = 1'b0;
    branch(32'd0);
    check("halt_redirect_halted", 64'(bus.halted), 64'd0);
    check("halt_redirect_valid", 64'(bus.id_valid), 64'd0);
    check("halt_redirect_addr", 64'(bus.imem_address), 64'd0);
    repeat (5) tick();
    check("stall_addr", 64'(bus.imem_address), 64'd8);
    check("stall_pc", 64'(bus.id_pc), 64'd0);
    check("stall_valid", 64'(bus.id_valid), 64'd1);
    check("stall_count", 64'(bus.fetch_count), 64'd9);
    expect_seq(32'd0, 7);
    bus.id_ready = 1'b1;
    wait_halt();
    check("drain_count", 64'(bus.fetch_count), 64'd14);
    bus.id_ready = 1'b0;
    branch(32'd0);
    repeat (2) tick();
    check("fill_pc", 64'(bus.id_pc), 64'd0);
    expect_seq(32'h10, 3);
    branch(32'h10);
    check("flush_valid", 64'(bus.id_valid), 64'd0);
    check("flush_addr", 64'(bus.imem_address), 64'h10);
    bus.id_ready = 1'b1;
    tick();
    check("target_valid", 64'(bus.id_valid), 64'd1);
    check("target_pc", 64'(bus.id_pc), 64'h10);
    wait_halt();
    check("flush_count", 64'(bus.fetch_count), 64'd19);
    expect_seq(32'h0C, 4);
    branch(32'h0E);
    check("align_addr", 64'(bus.imem_address), 64'h0C);
    wait_halt();
    check("align_count", 64'(bus.fetch_count), 64'd23);
    branch(32'h40);
    check("oob_halted", 64'(bus.halted), 64'd1);
    check("oob_addr", 64'(bus.imem_address), 64'h40);
    check("oob_valid", 64'(bus.id_valid), 64'd0);
    bus.id_ready = 1'b0;
    branch(32'd0);
    repeat (3) tick();
    check("pre_reset_count", 64'(bus.fetch_count), 64'd25);
    check("pre_reset_valid", 64'(bus.id_valid), 64'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", 64'(bus.id_valid), 64'd0);
    check("mid_rst_addr", 64'(bus.imem_address), 64'd0);
    check("mid_rst_count", 64'(bus.fetch_count), 64'd0);
    check("mid_rst_halted", 64'(bus.halted), 64'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_idle_valid", 64'(bus.id_valid), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
